// File: rtl/func_pkg.sv
// func_pkg: shared FSM encoding and truth-table width helpers for the programmable function unit.
package func_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_e;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    // One extra bit so the counter can hold TT_W itself without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(1 << n) + 1;
    endfunction

endpackage

// File: rtl/prog_func_unit_if.sv
// prog_func_unit_if: config, eval and sweep signals of the programmable function unit.
interface prog_func_unit_if #(
    parameter int N_IN = 4
);

    logic            cfg_load;
    logic            cfg_bit_valid;
    logic            cfg_bit;
    logic            eval_valid;
    logic [N_IN-1:0] eval_in;
    logic            eval_s;
    logic            eval_s_valid;
    logic            sweep_start;
    logic            sweep_valid;
    logic            sweep_ready;
    logic [N_IN-1:0] sweep_idx;
    logic            sweep_s;
    logic            sweep_last;
    logic            busy;

    modport master (
        output cfg_load, cfg_bit_valid, cfg_bit, eval_valid, eval_in, sweep_start, sweep_ready,
        input  eval_s, eval_s_valid, sweep_valid, sweep_idx, sweep_s, sweep_last, busy
    );

    modport slave (
        input  cfg_load, cfg_bit_valid, cfg_bit, eval_valid, eval_in, sweep_start, sweep_ready,
        output eval_s, eval_s_valid, sweep_valid, sweep_idx, sweep_s, sweep_last, busy
    );

endinterface

// File: rtl/tt_shift_loader.sv
// tt_shift_loader: LSB-first serial shadow register and bit counter for truth-table reloads.
module tt_shift_loader
    import func_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic                  cfg_bit,
    output logic                  load_done,
    output logic [tt_w(N_IN)-1:0] shadow
);

    localparam int TT_W = tt_w(N_IN);
    localparam int CW   = cnt_w(N_IN);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0] shadow_q, shadow_d;
    logic            take;

    assign load_done = cnt_q == CW'(TT_W);
    assign shadow    = shadow_q;

    always_comb begin
        take     = shift_en && !load_done;
        cnt_d    = clr ? '0 : cnt_q + CW'(take);
        shadow_d = take ? {cfg_bit, shadow_q[TT_W-1:1]} : shadow_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/prog_func_unit.sv
// prog_func_unit: reloadable 2^N_IN-entry truth table with a registered eval path and a
// valid/ready sweep engine that streams every entry for self-check.
module prog_func_unit
    import func_pkg::*;
#(
    parameter int                    N_IN    = 4,
    parameter logic [tt_w(N_IN)-1:0] TT_INIT = 16'h212F
) (
    input logic            clk,
    input logic            reset,
    prog_func_unit_if.slave bus
);

    localparam int TT_W = tt_w(N_IN);

    state_e          state_q, state_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic            eval_s_q, eval_s_d;
    logic            eval_s_valid_q;
    logic            sweep_valid_q, sweep_valid_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic            load_done;
    logic [TT_W-1:0] shadow;
    logic            xfer;
    logic            last;

    tt_shift_loader #(.N_IN(N_IN)) u_loader (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q != LOAD),
        .shift_en (state_q == LOAD && bus.cfg_bit_valid),
        .cfg_bit  (bus.cfg_bit),
        .load_done(load_done),
        .shadow   (shadow)
    );

    always_comb begin
        xfer    = sweep_valid_q && bus.sweep_ready;
        last    = &idx_q;
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus.cfg_load ? LOAD : bus.sweep_start ? SWEEP : IDLE;
            LOAD:    state_d = load_done ? IDLE : LOAD;
            SWEEP:   state_d = (xfer && last) ? IDLE : SWEEP;
            default: state_d = IDLE;
        endcase
        tt_d          = (state_q == LOAD && load_done) ? shadow : tt_q;
        eval_s_d      = bus.eval_valid ? tt_q[bus.eval_in] : eval_s_q;
        sweep_valid_d = (state_q == IDLE && !bus.cfg_load && bus.sweep_start) ||
                        (sweep_valid_q && !(xfer && last));
        // Index wraps to 0 naturally on the last beat.
        idx_d         = xfer ? idx_q + N_IN'(1) : idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            tt_q           <= TT_INIT;
            eval_s_q       <= 1'b0;
            eval_s_valid_q <= 1'b0;
            sweep_valid_q  <= 1'b0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            tt_q           <= tt_d;
            eval_s_q       <= eval_s_d;
            eval_s_valid_q <= bus.eval_valid;
            sweep_valid_q  <= sweep_valid_d;
            idx_q          <= idx_d;
        end
    end

    assign bus.eval_s       = eval_s_q;
    assign bus.eval_s_valid = eval_s_valid_q;
    assign bus.sweep_valid  = sweep_valid_q;
    assign bus.sweep_idx    = idx_q;
    assign bus.sweep_s      = sweep_valid_q && tt_q[idx_q];
    assign bus.sweep_last   = sweep_valid_q && last;
    assign bus.busy         = state_q != IDLE;

endmodule
